// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry
// flip-flop, LSB first, wrapped in a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    // Shared full-adder cell operating on the LSBs of the operand shifters.
    assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c        = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};

    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == RUN);
    assign w_last = w_step && (r_cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is folded into the load: B is inverted and the borrow-in
    // becomes carry-in, so the RUN datapath is always a plain add.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_acc   <= w_acc_next;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                // r_carry here is the carry into the MSB
                r_sum  <= w_acc_next;
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit instance for the
// handshake/timing scenarios and a 2-bit instance for exhaustive arithmetic.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start2, sub2, cin2;
    logic [1:0] a2, b2;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .ovf(ovf2)
    );

    // Issue one 8-bit operation and wait for done; stops at done's negedge.
    task automatic do_op8(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                          input logic c, output int lat, output int nbusy);
        @(negedge clk);
        sub8 = s; a8 = aa; b8 = bb; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat    = 1;
        nbusy  = busy8 ? 1 : 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy8) nbusy++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        n_checks++;
        if ({busy2, done2, sum2, cout2, ovf2} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset2 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy2, done2, sum2, cout2, ovf2);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_timing;
        int lat, nb;
        do_op8(1'b0, 8'h5A, 8'h3C, 1'b0, lat, nb);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL add_latency got %0d want 9", lat);
        end
        n_checks++;
        if (nb !== 8) begin
            n_fail++;
            $display("FAIL add_busy_cycles got %0d want 8", nb);
        end
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_5A_3C got sum=%h cout=%b ovf=%b want 96 0 1", sum8, cout8, ovf8);
        end
        // Results must hold while idle and through the next load/RUN.
        @(negedge clk);
        sub8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1} || busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_in_run got sum=%h cout=%b ovf=%b busy=%b want 96 0 1 busy=1",
                     sum8, cout8, ovf8, busy8);
        end
        while (!done8) @(negedge clk);
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_0_0_c1 got sum=%h cout=%b ovf=%b want FF 0 0", sum8, cout8, ovf8);
        end
    endtask

    task automatic test_add_edges;
        int lat, nb;
        do_op8(1'b0, 8'hFF, 8'h01, 1'b0, lat, nb);
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0} || lat !== 9) begin
            n_fail++;
            $display("FAIL add_FF_01 got sum=%h cout=%b ovf=%b lat=%0d want 00 1 0 lat=9",
                     sum8, cout8, ovf8, lat);
        end
        do_op8(1'b0, 8'h7F, 8'h00, 1'b1, lat, nb);
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1} || lat !== 9) begin
            n_fail++;
            $display("FAIL add_7F_00_c1 got sum=%h cout=%b ovf=%b lat=%0d want 80 0 1 lat=9",
                     sum8, cout8, ovf8, lat);
        end
    endtask

    task automatic test_sub;
        int lat, nb;
        do_op8(1'b1, 8'h10, 8'h20, 1'b0, lat, nb);
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0} || lat !== 9) begin
            n_fail++;
            $display("FAIL sub_10_20 got sum=%h cout=%b ovf=%b lat=%0d want F0 0 0 lat=9",
                     sum8, cout8, ovf8, lat);
        end
        do_op8(1'b1, 8'h80, 8'h01, 1'b0, lat, nb);
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1} || lat !== 9) begin
            n_fail++;
            $display("FAIL sub_80_01 got sum=%h cout=%b ovf=%b lat=%0d want 7F 1 1 lat=9",
                     sum8, cout8, ovf8, lat);
        end
    endtask

    task automatic test_back_to_back;
        int t_done[3];
        int nd   = 0;
        int k    = 0;
        int wide = 0;
        int nbad = 0;
        logic prev = 1'b0;
        @(negedge clk);
        sub8 = 1'b0; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        while (nd < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (done8 && prev) wide++;
            if (done8) begin
                t_done[nd] = k;
                if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) nbad++;
                nd++;
            end
            prev = done8;
        end
        start8 = 1'b0;
        @(negedge clk);
        if (done8) wide++;
        n_checks++;
        if (nd !== 3) begin
            n_fail++;
            $display("FAIL b2b_count got %0d done pulses want 3", nd);
        end else begin
            n_checks++;
            if (t_done[1] - t_done[0] !== 10 || t_done[2] - t_done[1] !== 10) begin
                n_fail++;
                $display("FAIL b2b_spacing got %0d,%0d want 10,10",
                         t_done[1] - t_done[0], t_done[2] - t_done[1]);
            end
        end
        n_checks++;
        if (wide !== 0) begin
            n_fail++;
            $display("FAIL b2b_done_width got %0d wide pulses want 0", wide);
        end
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL b2b_results got %0d wrong results want 0", nbad);
        end
    endtask

    task automatic test_run_isolation;
        int k = 0;
        @(negedge clk);
        sub8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        while (!done8 && k < 40) begin
            start8 = 1'($urandom_range(0, 1));
            sub8   = 1'($urandom_range(0, 1));
            cin8   = 1'($urandom_range(0, 1));
            a8     = 8'($urandom_range(0, 255));
            b8     = 8'($urandom_range(0, 255));
            @(negedge clk);
            k++;
        end
        start8 = 1'b0;
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0} || k !== 8) begin
            n_fail++;
            $display("FAIL run_isolation got sum=%h cout=%b ovf=%b k=%0d want F0 0 0 k=8",
                     sum8, cout8, ovf8, k);
        end
    endtask

    task automatic test_mid_run_reset;
        int lat, nb;
        int spurious = 0;
        @(negedge clk);
        sub8 = 1'b0; a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy got %b want 1", busy8);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_run_reset got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) spurious++;
        end
        n_checks++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL post_reset_idle got %0d active cycles want 0", spurious);
        end
        do_op8(1'b0, 8'h33, 8'h44, 1'b1, lat, nb);
        n_checks++;
        if ({sum8, cout8, ovf8} !== {8'h78, 1'b0, 1'b0} || lat !== 9) begin
            n_fail++;
            $display("FAIL post_reset_add got sum=%h cout=%b ovf=%b lat=%0d want 78 0 0 lat=9",
                     sum8, cout8, ovf8, lat);
        end
    endtask

    task automatic test_exhaustive_w2;
        int nbad = 0;
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 4; ia++) begin
                for (int ib = 0; ib < 4; ib++) begin
                    for (int c = 0; c < 2; c++) begin
                        int t, sv, sa, sb, lat;
                        logic [1:0] e_sum;
                        logic       e_cout, e_ovf;
                        sa = (ia > 1) ? ia - 4 : ia;
                        sb = (ib > 1) ? ib - 4 : ib;
                        if (s == 0) begin
                            t      = ia + ib + c;
                            sv     = sa + sb + c;
                            e_cout = (t > 3);
                        end else begin
                            t      = ia - ib - c;
                            sv     = sa - sb - c;
                            e_cout = (ia >= ib + c);
                        end
                        e_sum = 2'((t + 8) % 4);
                        e_ovf = (sv > 1) || (sv < -2);
                        @(negedge clk);
                        sub2 = 1'(s); a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(c); start2 = 1'b1;
                        @(negedge clk);
                        start2 = 1'b0;
                        lat = 1;
                        while (!done2 && lat < 10) begin
                            @(negedge clk);
                            lat++;
                        end
                        n_checks++;
                        if ({cout2, sum2, ovf2} !== {e_cout, e_sum, e_ovf} || lat !== 3) begin
                            n_fail++;
                            nbad++;
                            $display("FAIL w2 sub=%0d a=%0d b=%0d cin=%0d got cout=%b sum=%b ovf=%b lat=%0d want cout=%b sum=%b ovf=%b lat=3",
                                     s, ia, ib, c, cout2, sum2, ovf2, lat, e_cout, e_sum, e_ovf);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_add_timing;
        test_add_edges;
        test_sub;
        test_back_to_back;
        test_run_isolation;
        test_mid_run_reset;
        test_exhaustive_w2;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that generalises the single-bit full adder (a, b, cin -> sum, cout) to WIDTH-bit operands. It reuses one full-adder cell and a carry flip-flop, processing one bit per clock, LSB first. A start/busy/done handshake surrounds the datapath. It serves as the arithmetic unit for the lab's clocked datapath designs, where area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a - b - cin); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in (add) or borrow-in (sub); sampled with start
- busy  output  1  high while bits are being processed (RUN state)
- done  output  1  one-cycle pulse; result outputs valid from this cycle
- sum  output  WIDTH  result, held until the next accepted start
- cout  output  1  raw carry-out of the MSB; for subtract, 1 = no borrow
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - If start=1, go to RUN and load:
    - operand register A <= a
    - operand register B <= b XOR {WIDTH{sub}}
    - carry <= cin XOR sub
    - bit counter <= 0
  - sum, cout and ovf are not changed on this load.
- **RUN**
  - Each cycle, one full-add of A[0], B[0] and carry.
  - The result bit shifts into the MSB of the result shift register.
  - A and B shift right by one.
  - carry <= full-adder carry-out.
  - The counter increments.
  - When the counter equals WIDTH-1, the current cycle processes the MSB:
    - carry into the MSB is captured for ovf;
    - sum, cout and ovf registers are loaded with the final values;
    - the state goes to DONE.
- **DONE**
  - done=1 for exactly one cycle, then unconditionally back to IDLE.
  - start is ignored in DONE; it is re-sampled in IDLE on the following edge.
- start is ignored while in RUN; operand inputs may change freely after acceptance.
- Subtract semantics: a + ~b + ~cin. The result equals (a - b - cin) mod 2^WIDTH.
- Counter width is clog2(WIDTH). There is no wrap-around concern because the counter is cleared on every load.

## Timing
- Reset (rst=1 at an edge) gives state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and internal registers=0.
- Reset has priority over every other event, including mid-RUN. A partially computed result is discarded; sum, cout and ovf read 0.
- busy and done are registered decodes of the state; there are no combinational paths from inputs to outputs.
- Cycle numbering, with start sampled at edge k:
  - busy=1 in cycles k+1 .. k+WIDTH (WIDTH cycles).
  - done=1 in cycle k+WIDTH+1.
  - Latency from the start edge to done is WIDTH+1 cycles.
- Back-to-back throughput: with start held high, the next operation is accepted at edge k+WIDTH+2. That gives one result every WIDTH+2 cycles.
- sum, cout and ovf change only at the edge that enters DONE, or on reset. They are stable from the done cycle until the next result completes.

## Test plan
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, ovf=1. done occurs exactly 9 cycles after the start edge; busy is high for exactly 8 cycles.
- WIDTH=8, add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then add a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, sub, a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0, ovf=0. Then sub a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
- start held high continuously for three operations -> done pulses exactly WIDTH+2 cycles apart, never two cycles wide. Toggling a, b, sub and start during RUN does not alter the result.
- Assert rst at RUN cycle 4 of an operation -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0. A following start computes correctly from a clean state.
- WIDTH=2 exhaustive: all a, b, cin and sub combinations (64 cases) -> {cout, sum} and ovf match the reference model a ± b ± cin in every case.
